control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/instr_decode.sv | 71 +++++++
 rtl/control_sequencer.sv | 141 ++++++++++++++
 tb/tb_control_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode values, instruction field positions, FSM encoding and strobe bundle
// for the control sequencer and its decoder.
package ctrl_pkg;

   // Opcodes, instruction bits [31:28]
   localparam logic [3:0] OpNop   = 4'h0;
   localparam logic [3:0] OpAdd   = 4'h1;
   localparam logic [3:0] OpSub   = 4'h2;
   localparam logic [3:0] OpLdi   = 4'h3;
   localparam logic [3:0] OpStm   = 4'h4;
   localparam logic [3:0] OpCmp   = 4'h5;
   localparam logic [3:0] OpClrst = 4'h6;
   localparam logic [3:0] OpBr    = 4'h7;
   localparam logic [3:0] OpJmp   = 4'h8;
   localparam logic [3:0] OpHalt  = 4'hF;

   // Instruction field positions
   localparam int unsigned OpcMsb  = 31;
   localparam int unsigned OpcLsb  = 28;
   localparam int unsigned DestMsb = 27;
   localparam int unsigned DestLsb = 23;
   localparam int unsigned Src1Msb = 22;
   localparam int unsigned Src1Lsb = 18;
   localparam int unsigned Src2Msb = 17;
   localparam int unsigned Src2Lsb = 13;
   localparam int unsigned EqcBit  = 12;
   localparam int unsigned LtcBit  = 11;
   localparam int unsigned TgtMsb  = 7;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StWb,
      StHalt
   } state_e;

   typedef struct packed {
      logic alu_sum;
      logic wb;
      logic mem_wb;
      logic imm_wb;
      logic eq_in;
      logic lt_in;
      logic reset_st;
      logic set_st;
   } strobe_t;

endpackage

// File: rtl/instr_decode.sv
// Pure combinational instruction decode: strobes, register fields and control flags.
module instr_decode
   import ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output strobe_t     strb,
   output logic [4:0]  dest,
   output logic [4:0]  source1,
   output logic [4:0]  source2,
   output logic [7:0]  target,
   output logic        needs_wb,
   output logic        is_branch,
   output logic        is_cond,
   output logic        is_halt,
   output logic        is_illegal
);

   // Bits [10:8] carry no meaning in any instruction.
   logic unused_bits;
   assign unused_bits = ^ir[10:8];

   assign target = ir[TgtMsb:0];

   // Decode opcode into strobes and flags; LDI remaps its 15-bit immediate onto the fields.
   always_comb begin
      strb       = '0;
      needs_wb   = 1'b0;
      is_branch  = 1'b0;
      is_cond    = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      dest       = ir[DestMsb:DestLsb];
      source1    = ir[Src1Msb:Src1Lsb];
      source2    = ir[Src2Msb:Src2Lsb];
      unique case (ir[OpcMsb:OpcLsb])
         OpNop: begin
         end
         OpAdd: begin
            strb.alu_sum = 1'b1;
            strb.wb      = 1'b1;
            needs_wb     = 1'b1;
         end
         OpSub: begin
            strb.wb  = 1'b1;
            needs_wb = 1'b1;
         end
         OpLdi: begin
            strb.imm_wb = 1'b1;
            source1     = ir[27:23];
            source2     = ir[22:18];
            dest        = ir[17:13];
         end
         OpStm: strb.mem_wb = 1'b1;
         OpCmp: begin
            strb.set_st = 1'b1;
            needs_wb    = 1'b1;
         end
         OpClrst: strb.reset_st = 1'b1;
         OpBr: begin
            strb.eq_in = ir[EqcBit];
            strb.lt_in = ir[LtcBit];
            is_branch  = 1'b1;
            is_cond    = 1'b1;
         end
         OpJmp:  is_branch = 1'b1;
         OpHalt: is_halt   = 1'b1;
         default: is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute/writeback sequencer: owns pc, ir and the FSM; all outputs registered.
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int unsigned PC_W     = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_req,
   input  logic [31:0]     imem_data,
   input  logic            imem_valid,
   input  logic            st_match,
   output logic            alu_sum,
   output logic            wb,
   output logic            mem_wb,
   output logic            imm_wb,
   output logic            eq_in,
   output logic            lt_in,
   output logic            reset_st,
   output logic            set_st,
   output logic [4:0]      dest,
   output logic [4:0]      source1,
   output logic [4:0]      source2,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted,
   output logic            illegal
);

   state_e      state;
   logic [31:0] ir;
   strobe_t     strb_q;

   // Decoder sees the incoming word on the accepting FETCH cycle so outputs can be
   // registered into EXEC; during EXEC it sees ir itself.
   logic [31:0] dec_in;
   strobe_t     dec_strb;
   logic [4:0]  dec_dest, dec_src1, dec_src2;
   logic [7:0]  dec_target;
   logic        dec_needs_wb, dec_branch, dec_cond, dec_halt, dec_illegal;
   logic        taken;

   assign dec_in = (state == StFetch && imem_valid) ? imem_data : ir;

   instr_decode u_decode (
      .ir         (dec_in),
      .strb       (dec_strb),
      .dest       (dec_dest),
      .source1    (dec_src1),
      .source2    (dec_src2),
      .target     (dec_target),
      .needs_wb   (dec_needs_wb),
      .is_branch  (dec_branch),
      .is_cond    (dec_cond),
      .is_halt    (dec_halt),
      .is_illegal (dec_illegal)
   );

   assign taken     = dec_branch && (!dec_cond || st_match);
   assign imem_addr = pc;

   assign alu_sum  = strb_q.alu_sum;
   assign wb       = strb_q.wb;
   assign mem_wb   = strb_q.mem_wb;
   assign imm_wb   = strb_q.imm_wb;
   assign eq_in    = strb_q.eq_in;
   assign lt_in    = strb_q.lt_in;
   assign reset_st = strb_q.reset_st;
   assign set_st   = strb_q.set_st;

   // FSM, pc, ir and every registered output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= StIdle;
         pc       <= PC_W'(RESET_PC);
         ir       <= '0;
         strb_q   <= '0;
         dest     <= '0;
         source1  <= '0;
         source2  <= '0;
         imem_req <= 1'b0;
         busy     <= 1'b0;
         halted   <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  state    <= StFetch;
                  imem_req <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            StFetch: begin
               if (imem_valid) begin
                  ir       <= imem_data;
                  state    <= StExec;
                  imem_req <= 1'b0;
                  strb_q   <= dec_strb;
                  dest     <= dec_dest;
                  source1  <= dec_src1;
                  source2  <= dec_src2;
               end
            end
            StExec: begin
               strb_q  <= '0;
               illegal <= illegal | dec_illegal;
               pc      <= taken ? PC_W'(dec_target) : pc + PC_W'(1);
               if (dec_needs_wb) begin
                  state <= StWb;
               end else begin
                  dest    <= '0;
                  source1 <= '0;
                  source2 <= '0;
                  if (dec_halt) begin
                     state  <= StHalt;
                     busy   <= 1'b0;
                     halted <= 1'b1;
                  end else begin
                     state    <= StFetch;
                     imem_req <= 1'b1;
                  end
               end
            end
            StWb: begin
               dest     <= '0;
               source1  <= '0;
               source2  <= '0;
               state    <= StFetch;
               imem_req <= 1'b1;
            end
            StHalt: state <= StHalt;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed stimulus with a scoreboard queue; a monitor pops expectations per fetch.
module tb_control_sequencer;

   localparam int unsigned PC_W = 8;

   localparam logic [7:0] S_ALU = 8'h80;
   localparam logic [7:0] S_WB  = 8'h40;
   localparam logic [7:0] S_MEM = 8'h20;
   localparam logic [7:0] S_IMM = 8'h10;
   localparam logic [7:0] S_EQ  = 8'h08;
   localparam logic [7:0] S_LT  = 8'h04;
   localparam logic [7:0] S_RST = 8'h02;
   localparam logic [7:0] S_SET = 8'h01;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [31:0]     imem_data = 32'h0;
   logic            imem_valid = 1'b0;
   logic            st_match = 1'b0;
   logic [PC_W-1:0] imem_addr, pc;
   logic            imem_req, busy, halted, illegal;
   logic            alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st;
   logic [4:0]      dest, source1, source2;
   logic [7:0]      obs;

   assign obs = {alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st};

   always #5 clk = ~clk;

   control_sequencer #(.PC_W(PC_W), .RESET_PC(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .imem_addr  (imem_addr),
      .imem_req   (imem_req),
      .imem_data  (imem_data),
      .imem_valid (imem_valid),
      .st_match   (st_match),
      .alu_sum    (alu_sum),
      .wb         (wb),
      .mem_wb     (mem_wb),
      .imm_wb     (imm_wb),
      .eq_in      (eq_in),
      .lt_in      (lt_in),
      .reset_st   (reset_st),
      .set_st     (set_st),
      .dest       (dest),
      .source1    (source1),
      .source2    (source2),
      .pc         (pc),
      .busy       (busy),
      .halted     (halted),
      .illegal    (illegal)
   );

   typedef struct {
      logic [31:0] instr;
      int          wait_c;
      logic        match;
      logic [7:0]  addr;
      logic [7:0]  strb;
      logic [4:0]  dest;
      logic [4:0]  s1;
      logic [4:0]  s2;
      logic        wb;
      logic        ill;
      logic        halt;
   } vec_t;

   vec_t exp_q[$];
   vec_t prog[13];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input int wait_c, input logic match,
                               input logic [7:0] addr, input logic [7:0] strb,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic wbf, input logic ill, input logic halt);
      vec_t v;
      v.instr = instr; v.wait_c = wait_c; v.match = match; v.addr = addr; v.strb = strb;
      v.dest = d; v.s1 = s1; v.s2 = s2; v.wb = wbf; v.ill = ill; v.halt = halt;
      return v;
   endfunction

   // Instruction memory responder: wait for a request, stall, then present the word.
   task automatic run_vec(input vec_t v);
      int n = 0;
      while (!imem_req && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!imem_req) begin
         n_checks++;
         n_fail++;
         $display("FAIL req_timeout: imem_req never rose for addr 0x%0h", v.addr);
         return;
      end
      repeat (v.wait_c) begin
         @(posedge clk); #1;
      end
      imem_data  = v.instr;
      imem_valid = 1'b1;
      st_match   = v.match;
      exp_q.push_back(v);
      @(posedge clk); #1;
      imem_valid = 1'b0;
      imem_data  = 32'hDEAD_BEEF;
   endtask

   // Monitor: accept -> EXEC check -> post-EXEC (WB or next state) check.
   int   phase = 0;
   int   req_cnt = 0;
   logic last_ill = 1'b0;
   vec_t cur;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            phase    = 0;
            req_cnt  = 0;
            last_ill = 1'b0;
         end else if (phase == 1) begin
            check("exec_strobes", 32'(obs), 32'(cur.strb));
            check("exec_dest", 32'(dest), 32'(cur.dest));
            check("exec_source1", 32'(source1), 32'(cur.s1));
            check("exec_source2", 32'(source2), 32'(cur.s2));
            check("exec_imem_req", 32'(imem_req), 32'd0);
            check("exec_busy", 32'(busy), 32'd1);
            check("exec_illegal", 32'(illegal), 32'(last_ill));
            phase = 2;
         end else begin
            if (phase == 2) begin
               check("post_strobes", 32'(obs), 32'd0);
               check("post_illegal", 32'(illegal), 32'(cur.ill));
               last_ill = cur.ill;
               if (cur.wb) begin
                  check("wb_dest", 32'(dest), 32'(cur.dest));
                  check("wb_source1", 32'(source1), 32'(cur.s1));
                  check("wb_source2", 32'(source2), 32'(cur.s2));
                  check("wb_imem_req", 32'(imem_req), 32'd0);
                  check("wb_busy", 32'(busy), 32'd1);
               end else begin
                  check("post_fields", {17'd0, dest, source1, source2}, 32'd0);
                  check("post_imem_req", 32'(imem_req), 32'(!cur.halt));
                  check("post_halted", 32'(halted), 32'(cur.halt));
                  check("post_busy", 32'(busy), 32'(!cur.halt));
               end
               phase = 0;
            end else begin
               check("idle_strobes", 32'(obs), 32'd0);
            end
            if (imem_req) req_cnt++;
            else req_cnt = 0;
            if (imem_req && imem_valid) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_fetch: addr 0x%0h with empty scoreboard", imem_addr);
               end else begin
                  cur = exp_q.pop_front();
                  check("fetch_addr", 32'(imem_addr), 32'(cur.addr));
                  check("fetch_pc", 32'(pc), 32'(cur.addr));
                  check("fetch_req_cycles", 32'(req_cnt), 32'(cur.wait_c + 1));
                  phase = 1;
               end
               req_cnt = 0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //             instr                                         wt m  addr   strobes      d      s1     s2     wb ill hlt
      prog[0]  = mk({4'h1, 5'd3, 5'd1, 5'd2, 13'd0},                2, 0, 8'h00, S_ALU|S_WB, 5'd3,  5'd1,  5'd2,  1, 0, 0);
      prog[1]  = mk({4'h3, 15'h1234, 13'd0},                         1, 0, 8'h01, S_IMM,      5'h14, 5'h04, 5'h11, 0, 0, 0);
      prog[2]  = mk({4'h5, 5'd0, 5'd4, 5'd5, 13'd0},                0, 0, 8'h02, S_SET,      5'd0,  5'd4,  5'd5,  1, 0, 0);
      prog[3]  = mk({4'h7, 15'd0, 2'b10, 3'd0, 8'h40},              0, 1, 8'h03, S_EQ,       5'd0,  5'd0,  5'd0,  0, 0, 0);
      prog[4]  = mk({4'h5, 5'd0, 5'd4, 5'd5, 13'd0},                1, 0, 8'h40, S_SET,      5'd0,  5'd4,  5'd5,  1, 0, 0);
      prog[5]  = mk({4'h7, 15'd0, 2'b11, 3'd0, 8'h40},              0, 0, 8'h41, S_EQ|S_LT,  5'd0,  5'd0,  5'd0,  0, 0, 0);
      prog[6]  = mk({4'h8, 15'd0, 2'b00, 3'd0, 8'hFF},              0, 0, 8'h42, 8'h00,      5'd0,  5'd0,  5'd0,  0, 0, 0);
      prog[7]  = mk(32'h0,                                          1, 0, 8'hFF, 8'h00,      5'd0,  5'd0,  5'd0,  0, 0, 0);
      prog[8]  = mk({4'hA, 5'd7, 23'd0},                            0, 0, 8'h00, 8'h00,      5'd7,  5'd0,  5'd0,  0, 1, 0);
      prog[9]  = mk({4'h2, 5'd31, 5'd30, 5'd29, 13'd0},             3, 0, 8'h01, S_WB,       5'd31, 5'd30, 5'd29, 1, 1, 0);
      prog[10] = mk({4'h4, 5'd1, 5'd2, 5'd3, 13'd0},                0, 0, 8'h02, S_MEM,      5'd1,  5'd2,  5'd3,  0, 1, 0);
      prog[11] = mk({4'h6, 28'd0},                                  0, 0, 8'h03, S_RST,      5'd0,  5'd0,  5'd0,  0, 1, 0);
      prog[12] = mk({4'hF, 28'd0},                                  1, 0, 8'h04, 8'h00,      5'd0,  5'd0,  5'd0,  0, 1, 1);

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);

      // imem_valid while idle must be ignored
      @(posedge clk); #1;
      imem_data  = prog[0].instr;
      imem_valid = 1'b1;
      @(posedge clk); #1;
      imem_valid = 1'b0;
      check("idle_valid_busy", 32'(busy), 32'd0);
      check("idle_valid_pc", 32'(pc), 32'd0);

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      foreach (prog[i]) run_vec(prog[i]);

      // HALT is terminal even when start pulses
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("halt_halted", 32'(halted), 32'd1);
         check("halt_busy", 32'(busy), 32'd0);
         check("halt_imem_req", 32'(imem_req), 32'd0);
      end

      // Reset out of HALT acts asynchronously
      @(posedge clk); #1 rst = 1'b1;
      #1;
      check("halt_rst_pc", 32'(pc), 32'd0);
      check("halt_rst_halted", 32'(halted), 32'd0);
      check("halt_rst_illegal", 32'(illegal), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Jump somewhere, then reset in the middle of the next fetch wait
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      run_vec(mk({4'h8, 20'd0, 8'h20}, 0, 0, 8'h00, 8'h00, 5'd0, 5'd0, 5'd0, 0, 0, 0));
      @(posedge clk); #1;
      check("midfetch_req", 32'(imem_req), 32'd1);
      check("midfetch_addr", 32'(imem_addr), 32'h20);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("arst_imem_req", 32'(imem_req), 32'd0);
      check("arst_pc", 32'(pc), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 32'd0);

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      run_vec(mk({4'h1, 5'd3, 5'd1, 5'd2, 13'd0}, 2, 0, 8'h00, S_ALU|S_WB, 5'd3, 5'd1, 5'd2,
                 1, 0, 0));
      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
